// File: rtl/primus_pkg.sv
// Shared types for the primus instruction-memory responder.
//   imem_err_e : response error code (ok / misaligned / out of range)
//   NOP_INST   : instruction returned in place of RAM data on an error
//   imem_rsp_t : one buffered response (instruction, echoed address, error)
package primus_pkg;

    typedef enum logic [1:0] {
        IMEM_OK       = 2'b00,
        IMEM_MISALIGN = 2'b01,
        IMEM_OOR      = 2'b10
    } imem_err_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        imem_err_e   err;
    } imem_rsp_t;

endpackage

// File: rtl/primus_imem_rsp_fifo.sv
// Two-entry response FIFO for the instruction-memory responder.
//   clk_i, rst_ni : clock, synchronous active-low reset (clears entries to zero)
//   push_i        : write push_data_i at the tail (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   flush_i       : discard all entries; wins over push and pop
//   valid_o       : head entry present
//   head_o        : head entry; holds its value until popped
module primus_imem_rsp_fifo
    import primus_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push_i,
    input  imem_rsp_t push_data_i,
    input  logic      pop_i,
    input  logic      flush_i,
    output logic      valid_o,
    output imem_rsp_t head_o
);

    imem_rsp_t  mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       push_ok, pop_ok;

    assign push_ok = push_i & (cnt_q != 2'd2);
    assign pop_ok  = pop_i & (cnt_q != 2'd0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (push_ok) wr_ptr_d = ~wr_ptr_q;
            if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
            cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = (cnt_q != 2'd0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/primus_imem_responder.sv
// Instruction fetch responder: accepts word fetches over valid/ready, reads a
// synchronous instruction RAM and returns responses in order through a
// two-entry buffer. flush_i drops everything pending; the load port writes RAM.
//   req_valid_i/req_ready_o/req_addr_i        : fetch request (byte address)
//   rsp_valid_o/rsp_ready_i                   : response handshake
//   rsp_inst_o/rsp_addr_o/rsp_err_o           : instruction, echoed address, error
//   flush_i                                   : drop in-flight and buffered responses
//   ld_en_i/ld_idx_i/ld_data_i                : RAM word write port
module primus_imem_responder
    import primus_pkg::*;
#(
    parameter int unsigned  DEPTH_WORDS = 1024,
    localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_addr_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_inst_o,
    output logic [31:0]      rsp_addr_o,
    output logic [1:0]       rsp_err_o,
    input  logic             flush_i,
    input  logic             ld_en_i,
    input  logic [IDX_W-1:0] ld_idx_i,
    input  logic [31:0]      ld_data_i
);

    logic [31:0] mem [DEPTH_WORDS];

    // Occupancy counts the read stage plus buffered entries, so it bounds both.
    logic [1:0]  cnt_q, cnt_d;
    logic        rd_vld_q;
    logic [31:0] rd_addr_q;
    imem_err_e   rd_err_q;
    logic [31:0] rd_data_q;

    logic        accept, pop, rd_en;
    imem_err_e   req_err;
    logic [IDX_W-1:0] req_idx;
    imem_rsp_t   push_data, head;

    assign req_ready_o = rst_ni & ~ld_en_i & ~flush_i & (cnt_q < 2'd2);
    assign accept      = req_valid_i & req_ready_o;
    assign pop         = rsp_valid_o & rsp_ready_i & ~flush_i;
    assign req_idx     = req_addr_i[IDX_W+1:2];

    always_comb begin
        req_err = IMEM_OK;
        if (req_addr_i[1:0] != 2'b00) begin
            req_err = IMEM_MISALIGN;
        end else if ((req_addr_i >> (IDX_W + 2)) != 32'd0) begin
            req_err = IMEM_OOR;
        end
    end

    assign rd_en = accept & (req_err == IMEM_OK);

    // Read-first: a read and a write in the same edge see the old word.
    always_ff @(posedge clk_i) begin
        if (ld_en_i) mem[ld_idx_i] <= ld_data_i;
        if (rd_en)   rd_data_q     <= mem[req_idx];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            rd_vld_q  <= 1'b0;
            rd_addr_q <= 32'd0;
            rd_err_q  <= IMEM_OK;
        end else begin
            rd_vld_q <= accept;
            if (accept) begin
                rd_addr_q <= req_addr_i;
                rd_err_q  <= req_err;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q + {1'b0, accept} - {1'b0, pop};
        if (flush_i) cnt_d = 2'd0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= 2'd0;
        else         cnt_q <= cnt_d;
    end

    always_comb begin
        push_data.inst = (rd_err_q == IMEM_OK) ? rd_data_q : NOP_INST;
        push_data.addr = rd_addr_q;
        push_data.err  = rd_err_q;
    end

    primus_imem_rsp_fifo u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (rd_vld_q),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (flush_i),
        .valid_o     (rsp_valid_o),
        .head_o      (head)
    );

    assign rsp_inst_o = head.inst;
    assign rsp_addr_o = head.addr;
    assign rsp_err_o  = head.err;

endmodule
